hps_cfg_bank: RTL

Parametrised successor to the single-word HPS config decoder: a bank of NREGS config registers, each DW bits wide, written over the HPS user-I/O channel (io_uio framed, io_strobe per 16-bit word).
- Multi-word writes go to a shadow register and are committed atomically, so the core never sees a half-written value.
- Per-register valid flags and commit pulses replace the single cfg_ready.
- Sits in sys_top next to the HPS I/O sync logic, clocked by clk_sys.

---
 rtl/hps_cfg_pkg.sv | 22 ++
 rtl/hps_strobe_edge.sv | 35 +++
 rtl/hps_cfg_bank.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hps_cfg_pkg.sv
// Shared types and constants for the HPS config register bank.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package hps_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        SKIP,
        DONE
    } state_e;

    localparam logic [7:0] CMD_BASE_DEF    = 8'h01;
    localparam logic [7:0] CMD_RD_BASE_DEF = 8'h41;

    // Number of 16-bit HPS words needed to carry one dw-bit register.
    function automatic int words_per_reg(input int dw);
        return (dw + 15) / 16;
    endfunction

endpackage

// File: rtl/hps_strobe_edge.sv
// Strobe rising-edge detector qualified by the user-I/O frame.
// Latency: combinational outputs; one flop of strobe history.
// Backpressure: none, every qualified edge is reported exactly once.
//
// Ports:
//   clk_sys     in   system clock
//   io_uio      in   frame qualifier, high for one command
//   io_strobe   in   level word strobe from the HPS
//   ev          out  strobe 0->1 transition inside an open frame
//   frame_abort out  frame is closed this cycle (io_uio low)
module hps_strobe_edge (
    input  logic clk_sys,
    input  logic io_uio,
    input  logic io_strobe,
    output logic ev,
    output logic frame_abort
);

    logic old_strobe_d;
    logic old_strobe_q;

    always_comb begin
        old_strobe_d = io_strobe;
    end

    // Strobe history keeps tracking through reset so a strobe held high across
    // reset is not mistaken for a fresh edge once reset releases.
    always_ff @(posedge clk_sys) begin
        old_strobe_q <= old_strobe_d;
    end

    assign ev          = io_strobe & ~old_strobe_q & io_uio;
    assign frame_abort = ~io_uio;

endmodule

// File: rtl/hps_cfg_bank.sv
// Bank of NREGS config registers written atomically over the HPS user-I/O channel.
// Latency: last-word event sampled at edge N -> cfg updated and cfg_stb high after edge N.
// Backpressure: none; the HPS paces words with io_strobe, extra words are dropped.
//
// Ports:
//   clk_sys, reset  clock and synchronous active-high reset
//   io_uio          command frame, io_strobe word strobe, io_din data word
//   io_dout         readback word (zero unless HPS_CFG_READBACK_EN is defined)
//   cfg             committed registers, register i at [i*DW +: DW]
//   cfg_valid       sticky per-register "written since reset"
//   cfg_stb         one-cycle commit pulse per register
// Build option: define HPS_CFG_READBACK_EN to enable the readback commands.
module hps_cfg_bank
    import hps_cfg_pkg::*;
#(
    parameter int         NREGS       = 4,
    parameter int         DW          = 16,
    parameter logic [7:0] CMD_BASE    = CMD_BASE_DEF,
    parameter logic [7:0] CMD_RD_BASE = CMD_RD_BASE_DEF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               io_uio,
    input  logic               io_strobe,
    input  logic [15:0]        io_din,
    output logic [15:0]        io_dout,
    output logic [NREGS*DW-1:0] cfg,
    output logic [NREGS-1:0]   cfg_valid,
    output logic [NREGS-1:0]   cfg_stb
);

    localparam int WPR = words_per_reg(DW);
    localparam int SW  = WPR * 16;
    localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    // One extra count so readback can step past the last word.
    localparam int WCW = $clog2(WPR + 2);

    logic                ev;
    logic                frame_abort;

    state_e              state_d, state_q;
    logic [IW-1:0]       idx_d, idx_q;
    logic [WCW-1:0]      wc_d, wc_q;
    logic [SW-1:0]       shadow_d, shadow_q;
    logic [NREGS*DW-1:0] cfg_d, cfg_q;
    logic [NREGS-1:0]    vld_d, vld_q;
    logic [NREGS-1:0]    stb_d, stb_q;
    logic [SW-1:0]       shadow_new;

    logic [7:0]          wr_off;
    logic [7:0]          rd_off;
    logic                wr_hit;
    logic                rd_hit;

    hps_strobe_edge u_edge (
        .clk_sys     (clk_sys),
        .io_uio      (io_uio),
        .io_strobe   (io_strobe),
        .ev          (ev),
        .frame_abort (frame_abort)
    );

    // Offsets wrap mod 256, so a single unsigned compare covers both range ends.
    assign wr_off = io_din[7:0] - CMD_BASE;
    assign rd_off = io_din[7:0] - CMD_RD_BASE;
    assign wr_hit = 32'(wr_off) < NREGS;
    assign rd_hit = 32'(rd_off) < NREGS;

`ifdef HPS_CFG_READBACK_EN
    logic [15:0] dout_d, dout_q;

    // Word w of register r, zero-filled above DW and zero past the last word.
    function automatic logic [15:0] rd_word(input logic [NREGS*DW-1:0] bank,
                                            input logic [IW-1:0] r,
                                            input int w);
        logic [SW-1:0] ext;
        ext          = '0;
        ext[DW-1:0]  = bank[int'(r)*DW +: DW];
        if (w < WPR) begin
            return ext[w*16 +: 16];
        end
        return '0;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wc_d       = wc_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        vld_d      = vld_q;
        stb_d      = '0;
        shadow_new = shadow_q;
`ifdef HPS_CFG_READBACK_EN
        dout_d     = dout_q;
`endif
        if (int'(wc_q) < WPR) begin
            shadow_new[int'(wc_q)*16 +: 16] = io_din;
        end

        if (frame_abort) begin
            // Closing the frame drops any partial write.
            state_d  = IDLE;
            wc_d     = '0;
            shadow_d = '0;
`ifdef HPS_CFG_READBACK_EN
            dout_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev) begin
                        wc_d     = '0;
                        shadow_d = '0;
                        if (wr_hit) begin
                            state_d = WR;
                            idx_d   = wr_off[IW-1:0];
                        end
`ifdef HPS_CFG_READBACK_EN
                        else if (rd_hit) begin
                            state_d = RD;
                            idx_d   = rd_off[IW-1:0];
                            dout_d  = rd_word(cfg_q, rd_off[IW-1:0], 0);
                        end
`else
                        else if (rd_hit) begin
                            // Readback commands are swallowed without a response.
                            state_d = SKIP;
                        end
`endif
                        else begin
                            state_d = SKIP;
                        end
                    end
                end
                WR: begin
                    if (ev) begin
                        shadow_d = shadow_new;
                        if (int'(wc_q) == WPR - 1) begin
                            cfg_d[int'(idx_q)*DW +: DW] = shadow_new[DW-1:0];
                            vld_d[idx_q]                = 1'b1;
                            stb_d[idx_q]                = 1'b1;
                            state_d                     = DONE;
                        end else begin
                            wc_d = wc_q + 1'b1;
                        end
                    end
                end
`ifdef HPS_CFG_READBACK_EN
                RD: begin
                    if (ev) begin
                        if (int'(wc_q) < WPR) begin
                            wc_d = wc_q + 1'b1;
                        end
                        dout_d = rd_word(cfg_q, idx_q, int'(wc_q) + 1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wc_q     <= '0;
            shadow_q <= '0;
            cfg_q    <= '0;
            vld_q    <= '0;
            stb_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wc_q     <= wc_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            vld_q    <= vld_d;
            stb_q    <= stb_d;
        end
    end

`ifdef HPS_CFG_READBACK_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end
    assign io_dout = dout_q;
`else
    assign io_dout = '0;
`endif

    assign cfg       = cfg_q;
    assign cfg_valid = vld_q;
    assign cfg_stb   = stb_q;

endmodule
